// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_fifo : 16550 receive FIFO of {data, break, parity err, framing err}
// Revision     : 1.0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int fifo_width     = 11,
  parameter int fifo_depth     = 16,
  parameter int fifo_pointer_w = 4,
  parameter int fifo_counter_w = 5
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [fifo_width-1:0]     data_in,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      fifo_reset,
  input  logic                      reset_status,
  output logic [fifo_width-1:0]     data_out,
  output logic [fifo_counter_w-1:0] count,
  output logic                      overrun,
  output logic                      error_bit
);

  localparam logic [fifo_counter_w-1:0] depth_cnt = fifo_counter_w'(fifo_depth);
  localparam logic [fifo_pointer_w-1:0] last_ptr  = fifo_pointer_w'(fifo_depth - 1);

  logic [fifo_width-4:0]     ram [fifo_depth];
  logic [2:0]                status [fifo_depth];
  logic [fifo_pointer_w-1:0] top;
  logic [fifo_pointer_w-1:0] bottom;
  logic [fifo_pointer_w-1:0] top_next;
  logic [fifo_pointer_w-1:0] bottom_next;

  logic full;
  logic empty;
  logic wr;
  logic rd;
  logic set_overrun;

  assign full  = (count == depth_cnt);
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when paired with a pop, since
  // the pop frees the slot the push lands in.
  assign wr          = push && (!full || pop);
  assign rd          = pop && !empty;
  assign set_overrun = push && !pop && full;

  assign top_next    = (top == last_ptr)    ? '0 : top + 1'b1;
  assign bottom_next = (bottom == last_ptr) ? '0 : bottom + 1'b1;

  always_ff @(posedge clk) begin
    if (wr) begin
      ram[top] <= data_in[fifo_width-1:3];
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      top     <= '0;
      bottom  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < fifo_depth; i++) begin
        status[i] <= 3'b000;
      end
    end else if (fifo_reset) begin
      top     <= '0;
      bottom  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < fifo_depth; i++) begin
        status[i] <= 3'b000;
      end
    end else begin
      if (wr) begin
        top <= top_next;
      end
      if (rd) begin
        bottom <= bottom_next;
      end
      if (wr && !rd) begin
        count <= count + 1'b1;
      end else if (rd && !wr) begin
        count <= count - 1'b1;
      end
      // The set term is last so it wins over a same-cycle status clear.
      if (reset_status) begin
        overrun <= 1'b0;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end
      for (int i = 0; i < fifo_depth; i++) begin
        if (wr && (top == fifo_pointer_w'(i))) begin
          status[i] <= data_in[2:0];
        end else if (rd && (bottom == fifo_pointer_w'(i))) begin
          status[i] <= 3'b000;
        end
      end
    end
  end

  assign data_out = {ram[bottom], status[bottom]};

  always_comb begin
    error_bit = 1'b0;
    for (int i = 0; i < fifo_depth; i++) begin
      error_bit = error_bit | (|status[i]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [10:0] data_in = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        fifo_reset = 1'b0;
  logic        reset_status = 1'b0;
  logic [10:0] data_out;
  logic [4:0]  count;
  logic        overrun;
  logic        error_bit;

  int checks = 0;
  int failures = 0;

  uart_rx_fifo dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .data_in(data_in), .push(push), .pop(pop),
    .fifo_reset(fifo_reset), .reset_status(reset_status), .data_out(data_out),
    .count(count), .overrun(overrun), .error_bit(error_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; returns 1 time unit after the edge.
  task automatic cyc(input logic p, input logic q, input logic [10:0] d,
                     input logic fr, input logic rs);
    push = p; pop = q; data_in = d; fifo_reset = fr; reset_status = rs;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; fifo_reset = 1'b0; reset_status = 1'b0;
  endtask

  task automatic do_push(input logic [10:0] d);
    cyc(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    cyc(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
  endtask

  function automatic logic [10:0] frec(input int i);
    return 11'((32'h20 + i) << 3);
  endfunction

  function automatic logic [10:0] grec(input int i);
    return 11'((32'h80 + i) << 3);
  endfunction

  function automatic logic [10:0] arec(input int i);
    return 11'((32'h40 + i) << 3);
  endfunction

  initial begin
    // Power-on reset, checked before any clock edge
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_error", 32'(error_bit), 32'd0);
    chk("rst_status", 32'(data_out[2:0]), 32'd0);
    @(posedge clk); #1;
    wb_rst_i = 1'b0;

    // Async reset mid-operation with count=5
    do_push(11'h101); do_push(11'h108); do_push(11'h110);
    do_push(11'h118); do_push(11'h120);
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_error", 32'(error_bit), 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_overrun", 32'(overrun), 32'd0);
    chk("async_rst_error", 32'(error_bit), 32'd0);
    #1 wb_rst_i = 1'b0;
    @(posedge clk); #1;

    // Ordering
    do_push(11'h0A8); do_push(11'h7F8); do_push(11'h001);
    chk("ord_count", 32'(count), 32'd3);
    chk("ord_error", 32'(error_bit), 32'd1);
    chk("ord_head0", 32'(data_out), 32'h0A8);
    do_pop();
    chk("ord_head1", 32'(data_out), 32'h7F8);
    do_pop();
    chk("ord_head2", 32'(data_out), 32'h001);
    chk("ord_error_mid", 32'(error_bit), 32'd1);
    do_pop();
    chk("ord_count_end", 32'(count), 32'd0);
    chk("ord_error_end", 32'(error_bit), 32'd0);
    do_pop();
    chk("pop_empty_count", 32'(count), 32'd0);

    // Fill and overrun
    for (int i = 0; i < 16; i++) do_push(frec(i));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_overrun", 32'(overrun), 32'd0);
    do_push(11'h7FF);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_head", 32'(data_out), 32'(frec(0)));
    chk("ovr_error", 32'(error_bit), 32'd0);
    cyc(1'b0, 1'b0, 11'h000, 1'b0, 1'b1);
    chk("rs_clear", 32'(overrun), 32'd0);
    cyc(1'b1, 1'b0, 11'h7FF, 1'b0, 1'b1);
    chk("rs_set_wins", 32'(overrun), 32'd1);
    cyc(1'b0, 1'b0, 11'h000, 1'b0, 1'b1);
    chk("rs_clear2", 32'(overrun), 32'd0);

    // Wrap-around
    for (int i = 0; i < 10; i++) do_pop();
    chk("wrap_mid_count", 32'(count), 32'd6);
    for (int i = 0; i < 10; i++) do_push(grec(i));
    chk("wrap_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrap_seq%0d", i), 32'(data_out),
          32'((i < 6) ? frec(10 + i) : grec(i - 6)));
      do_pop();
    end
    chk("wrap_count_end", 32'(count), 32'd0);

    // Simultaneous push+pop at count=4
    for (int i = 0; i < 4; i++) do_push(arec(i));
    cyc(1'b1, 1'b1, 11'h555, 1'b0, 1'b0);
    chk("pp4_count", 32'(count), 32'd4);
    chk("pp4_head", 32'(data_out), 32'(arec(1)));
    chk("pp4_error", 32'(error_bit), 32'd1);
    do_pop(); do_pop(); do_pop();
    chk("pp4_last", 32'(data_out), 32'h555);
    do_pop();
    chk("pp4_empty", 32'(count), 32'd0);
    chk("pp4_error_end", 32'(error_bit), 32'd0);

    // Simultaneous push+pop at count=0
    cyc(1'b1, 1'b1, 11'h3C2, 1'b0, 1'b0);
    chk("pp0_count", 32'(count), 32'd1);
    chk("pp0_head", 32'(data_out), 32'h3C2);
    do_pop();

    // Simultaneous push+pop at count=16
    for (int i = 0; i < 16; i++) do_push(frec(i));
    cyc(1'b1, 1'b1, 11'h7F9, 1'b0, 1'b0);
    chk("pp16_count", 32'(count), 32'd16);
    chk("pp16_overrun", 32'(overrun), 32'd0);
    chk("pp16_head", 32'(data_out), 32'(frec(1)));
    chk("pp16_error", 32'(error_bit), 32'd1);

    // Flush with count=7, error present and overrun set
    do_push(11'h000);
    chk("fl_pre_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 9; i++) do_pop();
    chk("fl_pre_count", 32'(count), 32'd7);
    chk("fl_pre_error", 32'(error_bit), 32'd1);
    cyc(1'b0, 1'b0, 11'h000, 1'b1, 1'b0);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_error", 32'(error_bit), 32'd0);
    chk("fl_overrun", 32'(overrun), 32'd0);
    chk("fl_status", 32'(data_out[2:0]), 32'd0);
    do_push(11'h2AB);
    chk("fl_push_count", 32'(count), 32'd1);
    chk("fl_push_head", 32'(data_out), 32'h2AB);
    chk("fl_push_error", 32'(error_bit), 32'd1);
    do_pop();
    chk("fl_pop_count", 32'(count), 32'd0);

    // Flush has priority over a same-cycle push
    do_push(11'h111);
    cyc(1'b1, 1'b0, 11'h222, 1'b1, 1'b0);
    chk("fl_prio_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive FIFO of the 16550-compatible UART. Stores 11-bit received-character records: 8 data bits plus 3 status bits (break, parity error, framing error). It is written one-push-per-character by the receiver state machine and read by the register/LSR logic. It reports fill level, overrun, and an aggregate "error present in FIFO" flag used for LSR bit 7.

## Interface
- `fifo_width`, default 11: record width. Bits [fifo_width-1:3] are data; bits [2:0] are status.
- `fifo_depth`, default 16: number of entries.
- `fifo_pointer_w`, default 4: pointer width, log2(depth).
- `fifo_counter_w`, default 5: count width, able to hold 0..depth.

Ports:
- `clk`, in, 1: clock.
- `wb_rst_i`, in, 1: reset, asynchronous, active-high; clock clk.
- `data_in`, in, fifo_width: record to push.
- `push`, in, 1: single-cycle push strobe.
- `pop`, in, 1: single-cycle pop strobe.
- `fifo_reset`, in, 1: synchronous flush.
- `reset_status`, in, 1: synchronous clear of `overrun` (LSR read).
- `data_out`, out, fifo_width: entry at the read pointer (head).
- `count`, out, fifo_counter_w: number of stored entries.
- `overrun`, out, 1: sticky flag, set by a push into a full FIFO.
- `error_bit`, out, 1: high if any stored entry has a nonzero status field [2:0].

## Operation
- Storage is a circular buffer with write pointer `top` and read pointer `bottom`, each fifo_pointer_w bits wide. Both wrap from depth-1 to 0.
- The data field lives in a RAM-style array with combinational read. The status field lives in a per-entry register array so all entries can be ORed.
- Async reset (`wb_rst_i`): top=0, bottom=0, count=0, all status entries=0, overrun=0.
- Sync `fifo_reset` has priority over push/pop. It produces the same clearing as reset except the data RAM, which is not cleared. `overrun` is also cleared.
- Push only (push=1, pop=0):
  - If count<depth: write data_in at top, top+1, count+1.
  - If full: no write, pointers and count unchanged, overrun←1.
- Pop only (push=0, pop=1):
  - If count>0: status entry at bottom←0, bottom+1, count-1.
  - If empty: ignored.
- Push and pop together:
  - If count>0: write at top, top+1, bottom+1, status entry at old bottom←0 (unless it is being written), count unchanged. This applies also when full; no overrun in that case.
  - If count==0: behave as push only (count becomes 1, data not consumed).
- `reset_status`: overrun←0 synchronously. If the same cycle contains an overrun-causing push, the set wins.
- `data_out` is combinational: {ram[bottom], status[bottom]}. When empty, the status bits read 0 and the data bits are don't-care.
- `error_bit` = OR over all entries of |status[i]. Popped and flushed entries are zeroed, so it reflects only stored records.
- `count` never exceeds depth and never underflows.

## Timing
- All state updates occur on the rising clk edge. Outputs are driven directly from state and have no extra register stage.
- Push→visible: `count` and `error_bit` update the cycle after the push edge. If the FIFO was empty, `data_out` shows the new record the cycle after the push.
- Pop→next: `data_out` shows the following entry the cycle after the pop edge.
- `overrun` asserts the cycle after the offending push. It stays high until `reset_status`, `fifo_reset`, or `wb_rst_i`.
- Reset values: count=0, overrun=0, error_bit=0, data_out[2:0]=0.
- The receiver guarantees push is a one-cycle pulse. The FIFO does not edge-detect; a push held high pushes on every cycle.

## Test plan
- **Reset and empty:** assert wb_rst_i mid-operation with count=5 → count=0, overrun=0, error_bit=0 immediately, without waiting for a clock edge.
- **Ordering:** push 0x0A8 (data 0x15, status 0), 0x7F8, 0x001 → count=3, error_bit=1; pop ×3 → data_out sequence 0x0A8, 0x7F8, 0x001; count=0; error_bit=0 after the third pop.
- **Fill and overrun:**
  - Push 16 records → count=16.
  - 17th push → count stays 16, overrun=1, head unchanged.
  - Pulse reset_status → overrun=0.
- **Wrap-around:** push 16, pop 10, push 10 → count=16; popping all returns records in push order across the pointer wrap.
- **Simultaneous push+pop:**
  - count=4: push+pop → count=4; head advances by one; the new record appears last.
  - count=0: push+pop → count=1, data_out=pushed value.
  - count=16: push+pop → count=16, overrun stays 0.
- **Flush:** with count=7 and error_bit=1, pulse fifo_reset → count=0, error_bit=0, overrun=0 next cycle; a subsequent push and pop return the new data.
